// File: rtl/tick_timer_sched.sv
// Four-channel timeout scheduler: round-robin load port, per-channel down-counters
// on a selectable tick base, one-cycle registered ack and expire pulses.
module tick_timer_sched #(
    parameter int NCH = 4,
    parameter int CW  = 12
) (
    input  logic                mclk,
    input  logic                srst,
    input  logic [4:0]          tick,
    input  logic [NCH-1:0]      req,
    input  logic [3*NCH-1:0]    req_sel,
    input  logic [CW*NCH-1:0]   req_cnt,
    input  logic [NCH-1:0]      cancel,
    output logic [NCH-1:0]      ack,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      expire,
    output logic [CW-1:0]       cnt_dbg
);

    logic [NCH-1:0] ack_reg;
    logic [NCH-1:0] busy_reg;
    logic [NCH-1:0] expire_reg;
    logic [NCH-1:0] eligible;
    logic [NCH-1:0] grant_next;
    logic [1:0]     rr_reg;
    logic [1:0]     grant_idx;
    logic [1:0]     scan_idx;
    logic           grant_any;
    logic [CW-1:0]  ctr_arr [NCH];

    // A channel still showing ack is masked so a held req is never granted twice.
    always_comb begin
        eligible   = req & ~ack_reg & ~cancel;
        grant_any  = 1'b0;
        grant_idx  = rr_reg;
        scan_idx   = rr_reg;
        for (int k = 0; k < NCH; k++) begin
            scan_idx = rr_reg + 2'(k);
            if (!grant_any && eligible[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant_next = grant_any ? ({{(NCH-1){1'b0}}, 1'b1} << grant_idx) : '0;
    end

    always_ff @(posedge mclk) begin
        if (srst) begin
            ack_reg <= '0;
            rr_reg  <= 2'd0;
        end else begin
            ack_reg <= grant_next;
            if (grant_any) begin
                rr_reg <= grant_idx + 2'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic          busy_ch_reg;
            logic          expire_ch_reg;
            logic [CW-1:0] ctr_ch_reg;
            logic [2:0]    base_ch_reg;
            logic [2:0]    sel_in;
            logic          tick_hit;

            assign sel_in = req_sel[3*gi +: 3];

            always_comb begin
                case (base_ch_reg)
                    3'd0:    tick_hit = tick[0];
                    3'd1:    tick_hit = tick[1];
                    3'd2:    tick_hit = tick[2];
                    3'd3:    tick_hit = tick[3];
                    default: tick_hit = tick[4];
                endcase
            end

            // Priority: cancel, then (re)load, then count; a load discards same-edge ticks/expiry.
            always_ff @(posedge mclk) begin
                if (srst) begin
                    busy_ch_reg   <= 1'b0;
                    expire_ch_reg <= 1'b0;
                    ctr_ch_reg    <= '0;
                    base_ch_reg   <= 3'd0;
                end else begin
                    expire_ch_reg <= 1'b0;
                    if (cancel[gi]) begin
                        busy_ch_reg <= 1'b0;
                        ctr_ch_reg  <= '0;
                    end else if (grant_next[gi]) begin
                        busy_ch_reg <= 1'b1;
                        ctr_ch_reg  <= req_cnt[CW*gi +: CW];
                        base_ch_reg <= (sel_in > 3'd4) ? 3'd4 : sel_in;
                    end else if (busy_ch_reg) begin
                        if (ctr_ch_reg == '0) begin
                            // Zero-count load expires on the first edge after arming.
                            busy_ch_reg   <= 1'b0;
                            expire_ch_reg <= 1'b1;
                        end else if (tick_hit) begin
                            if (ctr_ch_reg == CW'(1)) begin
                                busy_ch_reg   <= 1'b0;
                                expire_ch_reg <= 1'b1;
                            end
                            ctr_ch_reg <= ctr_ch_reg - CW'(1);
                        end
                    end
                end
            end

            assign busy_reg[gi]   = busy_ch_reg;
            assign expire_reg[gi] = expire_ch_reg;
            assign ctr_arr[gi]    = ctr_ch_reg;
        end
    endgenerate

    assign ack     = ack_reg;
    assign busy    = busy_reg;
    assign expire  = expire_reg;
    assign cnt_dbg = ctr_arr[req_sel[1:0]];

endmodule

// File: doc/tick_timer_sched.md
# tick_timer_sched

Four-channel timeout scheduler running on the main clock and driven by the divided-time-base tick strobes (1 µs, 2 µs, 10 µs, 20 µs, 2 ms). Requesters load a timeout through a round-robin arbitrated load port. Each channel then counts down on its selected time base and reports expiry with a one-cycle pulse. It sits beside the clock divider and gives protocol engines timeouts without each of them owning counters and clock-gating logic.

## Interface
- NCH, 4, number of channels (fixed at 4 for this release)
- CW, 12, per-channel count width
- mclk  in  1  main clock; all logic is on its rising edge
- srst  in  1  synchronous active-high reset
- tick  in  5  single-mclk-cycle strobes: [0]=1 µs, [1]=2 µs, [2]=10 µs, [3]=20 µs, [4]=2 ms
- req  in  NCH  load request per channel; held until ack
- req_sel  in  3*NCH  time-base select per channel (bits 3i+2:3i); values 5..7 behave as 4
- req_cnt  in  CW*NCH  timeout count in ticks per channel (bits CW*i+CW-1:CW*i)
- cancel  in  NCH  single-cycle disarm per channel
- ack  out  NCH  registered one-cycle load acknowledge
- busy  out  NCH  channel armed
- expire  out  NCH  registered one-cycle expiry pulse
- cnt_dbg  out  CW  remaining count of the channel picked by req_sel[2:0]&3 (debug readback)

## Operation
- Per-channel state: IDLE (busy=0) or ARMED (busy=1). Each channel holds a CW-bit counter and a 3-bit base.
- Eligible set at each edge = req & ~ack & ~cancel. A channel whose ack is high is masked, so a held req is never granted twice.
- Arbiter: round-robin pointer rr (2 bits).
  - The first eligible channel searching rr, rr+1, … mod 4 is granted; at most one grant per cycle.
  - After a grant to channel g, rr <= g+1 mod 4. With no grant, rr holds.
- Grant to channel g, registered at the edge:
  - ack[g]=1 for one cycle; ctr[g] <= req_cnt[g]; base[g] <= req_sel[g]; state ARMED.
  - This applies whether g was IDLE or ARMED (re-arm restarts the count). Any expiry of g due on the same edge is suppressed.
- Load with count 0: the channel goes ARMED, then expires on the next edge without waiting for a tick.
- ARMED channel on an edge where tick[base] is high:
  - ctr > 1: ctr <= ctr-1.
  - ctr == 1: ctr <= 0, state IDLE, expire pulse.
- Cancel[i] on an edge: state IDLE, ctr <= 0, no expire. Cancel overrides a tick expiry on the same edge. Cancel also blocks the grant to i on that edge; a held req[i] competes again on the next edge.
- Ticks never accumulate: a tick seen on the same edge as a load is ignored for that channel.
- Requester rule: req[i] is dropped on the edge after ack[i] is seen. req_sel and req_cnt must be stable while req is high.

## Timing
- Reset (srst sampled high): ack=0, busy=0, expire=0, all ctr=0, base=0, rr=0, cnt_dbg=0. Reset overrides every other event.
- req rising before edge k, with the channel granted at k: ack high during cycle k..k+1 and busy high from k.
- Expiry: the tick on edge t that moves ctr from 1 to 0 gives expire high during cycle t..t+1 and busy low from t.
- A timeout of N ticks expires on the N-th selected tick strictly after the load edge. Real time is therefore between (N-1) and N tick periods.
- Worst-case grant latency with all four channels requesting is 4 cycles per requester (round-robin fairness).
- Several channels may expire on the same edge; each has its own expire bit.
- All outputs are registered. There is no combinational path from inputs to outputs except cnt_dbg, which is a mux of registered counters.

## Test plan
- Reset mid-count: arm ch0, count=5, base 1 µs; assert srst after 2 ticks. Required: busy=0 and expire never pulses.
- Single load: ch1, sel=2, cnt=3, 10 µs ticks every 100 cycles starting at cycle 50 after the load. Required: ack 1 cycle after req; expire on the third tick edge; busy low afterwards.
- Fairness: req=4'b1111 held from rr=0, each req dropped after its ack. Required: ack order ch0, ch1, ch2, ch3 on consecutive edges; rr=0 at the end. Repeat from rr=2 and require order 2, 3, 0, 1.
- Zero count: ch2, cnt=0. Required: ack at edge k, expire at edge k+1 with no tick applied.
- Collisions, ch3 armed with ctr=1:
  - Tick and cancel on the same edge: no expire; busy=0.
  - Re-arm with cnt=7 granted on the tick edge: no expire; ctr=7.
- Invalid select: sel=6, cnt=2. Required: decrements only on tick[4]; expires on the second 2 ms tick.
